sp_mem_arbiter: RTL and testbench
=================================

Name: sp_mem_arbiter

Overview:
- Sequences shared-memory access for the N SP cores of one SM onto a single-port memory.
- Consumes the per-core address/data vectors and the core-wide MRead/MWrite command.
- Services enabled cores one at a time in ascending index order and returns read data per core.
- Raises MReady once every enabled core has been serviced, using a 4-phase handshake with the SM controller.

Parameters:
- N_CORES, 8, number of SP cores; matches the `N_CORES define.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MRead  in  1  read command, level; held by the controller until MReady.
- MWrite  in  1  write command, level; held until MReady.
- MReady  out  1  all enabled cores serviced; level.
- en  in  N_CORES  per-core enable mask.
- addr_flat  in  N_CORES*AW  core i address at [i*AW +: AW].
- data_flat  in  N_CORES*DW  core i write data at [i*DW +: DW].
- q_flat  out  N_CORES*DW  core i read data at [i*DW +: DW]; registered.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_ack  in  1  memory accepted the access; mem_rdata is valid in the same cycle for reads.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (synchronous, active-high) → state IDLE. Outputs: MReady=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, q_flat=0. Internal index = 0.
- States: IDLE, ACCESS, DONE.
- IDLE, when (MRead|MWrite)=1:
  - latch en, addr_flat, data_flat and op.
  - op = write if MWrite=1; MWrite has priority when both are asserted.
  - if the latched en ≠ 0: index = lowest set bit, go to ACCESS.
  - else go to DONE.
- ACCESS:
  - mem_req=1, mem_we=op, mem_addr and mem_wdata taken from latched core[index].
  - Outputs are held stable while mem_ack=0.
  - On mem_ack=1:
    - if op is read, q[index] ← mem_rdata.
    - index ← next higher set bit of the latched en.
    - if none remains, go to DONE.
  - mem_req stays high across back-to-back accesses. A zero-wait memory therefore completes one core per cycle.
- DONE: MReady=1, mem_req=0. Stay while (MRead|MWrite)=1; go to IDLE when both are 0. MReady drops the cycle after the command drops.
- Timing:
  - Latency from command to MReady = 2 + Σ(wait cycles) + k, with k = popcount(en).
  - en=0 → MReady asserts 2 cycles after the command; no memory access occurs.
- Inputs are ignored after latching. Changes to en, addr or data during ACCESS or DONE have no effect.
- q of disabled cores, and all q during a write, hold their previous values.
- Reset mid-ACCESS: mem_req=0 the next cycle and the in-flight access is abandoned. The memory must tolerate a dropped request.
- Duplicate addresses on a write: each access is issued in index order, so the highest enabled index wins.

Optional Feature:
- Macro: SP_MEM_READ_COALESCE_EN.
- Defined: during a read, if core[index] has the same latched address as the previously serviced core in this command:
  - q[index] ← that core's captured data.
  - no mem_req is issued; one cycle is spent.
  - coalesced hits are counted in an 8-bit saturating output coalesce_cnt, which clears on reset.
- Undefined: every enabled core issues a memory access, and the coalesce_cnt port is absent.

Decomposition:
- Package sp_mem_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
  - the OP_READ/OP_WRITE constants.
  - default AW/DW.
- One sub-module: sp_next_index, a combinational priority finder that returns the next set bit above a given index plus a "none" flag. It is used both at latch time and on each ack.

Test Plan:
- Read with en=8'hFF, addr_i = 16'h0100+i, memory returning addr^16'hA5A5 with zero wait → 8 consecutive acks, q_i = (16'h0100+i)^16'hA5A5, MReady at cycle 10 after MRead.
- Write with en=8'b1010_0101, data_i = 16'h1000+i → exactly 4 writes to cores 0, 2, 5, 7 in that order; no q change; MReady high until MWrite drops.
- en=8'h00 with MRead → no mem_req ever; MReady 2 cycles later; deasserting MRead → MReady=0 the next cycle.
- Memory with 3 wait cycles per access, en=8'h03 → mem_addr stable while mem_ack=0; MReady at cycle 2+6+2=10.
- Synchronous reset asserted mid-ACCESS (after the 2nd ack of en=8'hFF) → next cycle mem_req=0, MReady=0, q=0; a new MRead restarts from core 0.
- With SP_MEM_READ_COALESCE_EN defined, read with en=8'h0F and all addresses = 16'h0040 → single mem_req, q0..q3 equal, coalesce_cnt=3.

Source files
------------

// File: rtl/sp_mem_pkg.sv
// Shared definitions for the SP shared-memory arbiter: FSM encoding, op codes, default widths.
`ifndef N_CORES
`define N_CORES 8
`endif

package sp_mem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
endpackage

// File: rtl/sp_next_index.sv
// Combinational priority finder: lowest set bit of mask above 'from' (or at it when incl=1).
module sp_next_index #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] from,
  input  logic          incl,
  output logic [IW-1:0] nxt,
  output logic          none
);
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    // Descending scan so the lowest qualifying index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from)) || (incl && (i == int'(from))))) begin
        nxt  = IW'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/sp_mem_arbiter.sv
// Serialises per-core shared-memory accesses of one SM onto a single-port memory.
// Optional read coalescing of repeated addresses: define SP_MEM_READ_COALESCE_EN.
module sp_mem_arbiter
  import sp_mem_pkg::*;
#(
  parameter int N_CORES = `N_CORES,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MRead,
  input  logic                  MWrite,
  output logic                  MReady,
  input  logic [N_CORES-1:0]    en,
  input  logic [N_CORES*AW-1:0] addr_flat,
  input  logic [N_CORES*DW-1:0] data_flat,
  output logic [N_CORES*DW-1:0] q_flat,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_ack,
`ifdef SP_MEM_READ_COALESCE_EN
  output logic [7:0]            coalesce_cnt,
`endif
  input  logic [DW-1:0]         mem_rdata
);
  localparam int IW = $clog2(N_CORES);

  state_t                  state;
  logic [IW-1:0]           idx;
  logic                    op_l;
  logic [N_CORES-1:0]      en_l;
  logic [N_CORES*AW-1:0]   addr_l;
  logic [N_CORES*DW-1:0]   data_l;
  logic [IW-1:0]           first_idx, next_idx;
  logic                    first_none, next_none;
  logic                    coal_step, step;

  sp_next_index #(.N(N_CORES), .IW(IW)) u_first (
    .mask(en), .from('0), .incl(1'b1), .nxt(first_idx), .none(first_none)
  );

  sp_next_index #(.N(N_CORES), .IW(IW)) u_next (
    .mask(en_l), .from(idx), .incl(1'b0), .nxt(next_idx), .none(next_none)
  );

`ifdef SP_MEM_READ_COALESCE_EN
  logic [DW-1:0] prev_data;
  logic          next_coal;
  // An ACCESS cycle without a request is a coalesced hit on the previous core's data.
  assign coal_step = (state == ACCESS) && !mem_req;
  assign next_coal = (op_l == OP_READ) &&
                     (addr_l[next_idx*AW +: AW] == addr_l[idx*AW +: AW]);
`else
  assign coal_step = 1'b0;
`endif
  assign step = (mem_req && mem_ack) || coal_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      MReady    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      q_flat    <= '0;
      idx       <= '0;
`ifdef SP_MEM_READ_COALESCE_EN
      coalesce_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          MReady <= 1'b0;
          if (MRead || MWrite) begin
            en_l   <= en;
            addr_l <= addr_flat;
            data_l <= data_flat;
            op_l   <= MWrite ? OP_WRITE : OP_READ;
            if (!first_none) begin
              idx       <= first_idx;
              mem_req   <= 1'b1;
              mem_we    <= MWrite ? OP_WRITE : OP_READ;
              mem_addr  <= addr_flat[first_idx*AW +: AW];
              mem_wdata <= data_flat[first_idx*DW +: DW];
              state     <= ACCESS;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCESS: begin
          if (step) begin
            if (op_l == OP_READ) begin
`ifdef SP_MEM_READ_COALESCE_EN
              q_flat[idx*DW +: DW] <= mem_req ? mem_rdata : prev_data;
              if (mem_req) prev_data <= mem_rdata;
`else
              q_flat[idx*DW +: DW] <= mem_rdata;
`endif
            end
`ifdef SP_MEM_READ_COALESCE_EN
            if (coal_step && (coalesce_cnt != 8'hFF)) coalesce_cnt <= coalesce_cnt + 8'd1;
`endif
            if (next_none) begin
              mem_req <= 1'b0;
              state   <= DONE;
            end else begin
              idx       <= next_idx;
              mem_addr  <= addr_l[next_idx*AW +: AW];
              mem_wdata <= data_l[next_idx*DW +: DW];
`ifdef SP_MEM_READ_COALESCE_EN
              mem_req   <= !next_coal;
`else
              mem_req   <= 1'b1;
`endif
            end
          end
        end
        DONE: begin
          mem_req <= 1'b0;
          if (MRead || MWrite) begin
            MReady <= 1'b1;
          end else begin
            MReady <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed and randomized bench for sp_mem_arbiter against a transaction-level reference model.
module tb_sp_mem_arbiter;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           MRead, MWrite, MReady;
  logic [N-1:0]   en;
  logic [N*16-1:0] addr_flat, data_flat, q_flat;
  logic           mem_req, mem_we, mem_ack;
  logic [15:0]    mem_addr, mem_wdata, mem_rdata;
`ifdef SP_MEM_READ_COALESCE_EN
  logic [7:0]     coalesce_cnt;
`endif

  sp_mem_arbiter dut (
    .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .MReady(MReady),
    .en(en), .addr_flat(addr_flat), .data_flat(data_flat), .q_flat(q_flat),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
`ifdef SP_MEM_READ_COALESCE_EN
    .coalesce_cnt(coalesce_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-port memory environment: fixed wait states per access, ack combinational.
  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } acc_t;
  acc_t        log_q[$];
  logic [15:0] mem_arr [0:65535];
  logic        mem_init;
  int          wcnt = 0;
  int          cur_wait = 0;

  assign mem_ack   = mem_req && (wcnt == cur_wait);
  assign mem_rdata = mem_arr[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem_arr[i] <= 16'(i) ^ 16'hA5A5;
    end else if (mem_req && mem_ack && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    if (mem_req && mem_ack) begin
      log_q.push_back('{mem_we, mem_addr, mem_wdata});
      wcnt <= 0;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // Request attributes must not move while the memory is stalling.
  logic [32:0] held;
  logic        held_v = 1'b0;
  always @(negedge clk) begin
    if (mem_req && !mem_ack && held_v)
      check("stall_stable", {95'd0, mem_we, mem_addr, mem_wdata}, {95'd0, held});
    held   = {mem_we, mem_addr, mem_wdata};
    held_v = mem_req && !mem_ack;
  end

  logic [15:0] cmd_addr [N];
  logic [15:0] cmd_data [N];
  logic [15:0] exp_q [N];
  int          exp_cc = 0;

  function automatic logic [127:0] pack_q();
    logic [127:0] r;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = exp_q[i];
    return r;
  endfunction

  task automatic drive_cmd(input logic wr, input logic both, input logic [7:0] e);
    MRead  = !wr || both;
    MWrite = wr;
    en     = e;
    for (int i = 0; i < N; i++) begin
      addr_flat[i*16 +: 16] = cmd_addr[i];
      data_flat[i*16 +: 16] = cmd_data[i];
    end
  endtask

  task automatic run_cmd(input string tag, input logic wr, input logic both,
                         input logic [7:0] e, input int wt);
    int   exp_lat, lat, prev;
    logic coal;
    acc_t exp_log[$];
    exp_lat = 2;
    prev = -1;
    for (int i = 0; i < N; i++) begin
      if (e[i]) begin
        coal = 1'b0;
`ifdef SP_MEM_READ_COALESCE_EN
        coal = !wr && (prev >= 0) && (cmd_addr[i] == cmd_addr[prev]);
`endif
        if (coal) begin
          exp_lat += 1;
          exp_q[i] = exp_q[prev];
          if (exp_cc < 255) exp_cc++;
        end else begin
          exp_lat += wt + 1;
          exp_log.push_back('{wr, cmd_addr[i], cmd_data[i]});
          if (!wr) exp_q[i] = mem_arr[cmd_addr[i]];
        end
        prev = i;
      end
    end
    cur_wait = wt;
    log_q.delete();
    drive_cmd(wr, both, e);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        en        = 8'($urandom);
        addr_flat = {$urandom, $urandom, $urandom, $urandom};
        data_flat = {$urandom, $urandom, $urandom, $urandom};
      end
      if (MReady) break;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_nacc"}, 128'(log_q.size()), 128'(exp_log.size()));
    for (int j = 0; j < exp_log.size() && j < log_q.size(); j++) begin
      check($sformatf("%s_acc%0d", tag, j),
            {95'd0, log_q[j].we, log_q[j].addr, wr ? log_q[j].wdata : 16'h0},
            {95'd0, exp_log[j].we, exp_log[j].addr, wr ? exp_log[j].wdata : 16'h0});
    end
    check({tag, "_q"}, q_flat, pack_q());
`ifdef SP_MEM_READ_COALESCE_EN
    check({tag, "_ccnt"}, 128'(coalesce_cnt), 128'(exp_cc));
`endif
    repeat (2) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, 128'({MReady, mem_req}), 128'(2'b10));
    end
    MRead  = 1'b0;
    MWrite = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop"}, 128'({MReady, mem_req}), 128'(2'b00));
  endtask

  initial begin
    int guard;
    reset = 1'b1; mem_init = 1'b1;
    MRead = 1'b0; MWrite = 1'b0; en = '0; addr_flat = '0; data_flat = '0;
    for (int i = 0; i < N; i++) exp_q[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; mem_init = 1'b0;
    check("rst_ctrl", 128'({MReady, mem_req, mem_we}), 128'(3'b000));
    check("rst_addr", 128'({mem_addr, mem_wdata}), 128'(0));
    check("rst_q", q_flat, 128'(0));

    for (int i = 0; i < N; i++) cmd_addr[i] = 16'h0100 + 16'(i);
    run_cmd("rd_all", 1'b0, 1'b0, 8'hFF, 0);

    for (int i = 0; i < N; i++) begin
      cmd_addr[i] = 16'h0300 + 16'(i);
      cmd_data[i] = 16'h1000 + 16'(i);
    end
    run_cmd("wr_a5", 1'b1, 1'b0, 8'b1010_0101, 0);
    run_cmd("rd_none", 1'b0, 1'b0, 8'h00, 0);
    run_cmd("rd_wait", 1'b0, 1'b0, 8'h03, 3);
    run_cmd("rd_back", 1'b0, 1'b0, 8'hA5, 1);

    for (int i = 0; i < N; i++) cmd_data[i] = 16'h2000 + 16'(i);
    for (int i = 0; i < N; i++) cmd_addr[i] = 16'h0400;
    run_cmd("wr_dup", 1'b1, 1'b1, 8'h16, 0);
    check("wr_dup_win", 128'(mem_arr[16'h0400]), 128'(16'h2004));

    // Reset in the middle of a read sweep.
    for (int i = 0; i < N; i++) cmd_addr[i] = 16'h0100 + 16'(i);
    cur_wait = 0;
    log_q.delete();
    drive_cmd(1'b0, 1'b0, 8'hFF);
    guard = 0;
    while (log_q.size() < 2 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rst_mid_reach", 128'(log_q.size() >= 2), 128'(1));
    reset = 1'b1; MRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_ctrl", 128'({MReady, mem_req}), 128'(2'b00));
    check("rst_mid_q", q_flat, 128'(0));
    for (int i = 0; i < N; i++) exp_q[i] = '0;
    exp_cc = 0;
    run_cmd("rd_restart", 1'b0, 1'b0, 8'hFF, 0);

`ifdef SP_MEM_READ_COALESCE_EN
    for (int i = 0; i < N; i++) cmd_addr[i] = 16'h0040;
    run_cmd("rd_coal", 1'b0, 1'b0, 8'h0F, 0);
`endif

    for (int t = 0; t < 24; t++) begin
      logic       wr;
      logic [7:0] e;
      wr = 1'($urandom_range(0, 1));
      e  = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        cmd_addr[i] = ($urandom_range(0, 1) == 1) ? 16'h0200 + 16'($urandom_range(0, 3))
                                                  : 16'($urandom);
        cmd_data[i] = 16'($urandom);
      end
      run_cmd($sformatf("rnd%0d", t), wr, 1'($urandom_range(0, 1)), e, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
